// File: rtl/minsoc_clock_divider_gen_pkg.sv
// minsoc clock divider: shared divisor encodings.
// Imported by the channel and top-level files.
package minsoc_clock_divider_gen_pkg;

  localparam int MINSOC_CLKDIV_STOP = 0;
  localparam int MINSOC_CLKDIV_MIN  = 2;

endpackage

// File: rtl/minsoc_clock_divider_chan.sv
// minsoc clock divider: one channel with counter, divisors
// and glitch-free output flops.
module minsoc_clock_divider_chan
  import minsoc_clock_divider_gen_pkg::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DIV_WIDTH-1:0] wr_data,
  input  logic                 sync,
  output logic [DIV_WIDTH-1:0] div,
  output logic                 clk_div,
  output logic                 stb,
  output logic                 run
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_pend;
  logic [DIV_WIDTH-1:0] wr_val;
  logic [DIV_WIDTH-1:0] last;
  logic [DIV_WIDTH:0]   hi_len;
  logic                 active;
  logic                 wrap;

  // A divisor of 1 cannot produce a two-phase clock, so it becomes 2.
  assign wr_val = (wr_data == DIV_WIDTH'(1))
                ? DIV_WIDTH'(MINSOC_CLKDIV_MIN)
                : wr_data;

  assign active = div != DIV_WIDTH'(MINSOC_CLKDIV_STOP);
  assign last   = div - 1'b1;
  assign wrap   = cnt == last;
  assign hi_len = ({1'b0, div} + 1'b1) >> 1;
  assign run    = active;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      div      <= DIV_WIDTH'(DEFAULT_DIV);
      div_pend <= DIV_WIDTH'(DEFAULT_DIV);
      clk_div  <= 1'b0;
      stb      <= 1'b0;
    end else begin
      if (wr_en) begin
        div_pend <= wr_val;
      end
      if (sync || !active) begin
        cnt     <= '0;
        div     <= div_pend;
        clk_div <= 1'b0;
        stb     <= 1'b0;
      end else begin
        clk_div <= {1'b0, cnt} < hi_len;
        stb     <= cnt == '0;
        // Divisor swaps only at the period boundary.
        if (wrap) begin
          cnt <= '0;
          div <= div_pend;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/minsoc_clock_divider_gen.sv
// minsoc clock divider: multi-channel programmable divider,
// write decode, sync fan-out and divisor readback.
module minsoc_clock_divider_gen
  import minsoc_clock_divider_gen_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 5,
  parameter int SEL_WIDTH   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [SEL_WIDTH-1:0] wr_sel_i,
  input  logic [DIV_WIDTH-1:0] wr_data_i,
  input  logic                 sync_i,
  input  logic [SEL_WIDTH-1:0] rd_sel_i,
  output logic [DIV_WIDTH-1:0] rd_data_o,
  output logic [CHANNELS-1:0]  clk_o,
  output logic [CHANNELS-1:0]  stb_o,
  output logic [CHANNELS-1:0]  run_o
);

  logic [DIV_WIDTH-1:0] div_act [CHANNELS];
  logic [CHANNELS-1:0]  wr_hit;

  // Selects beyond the last channel match nothing.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_en_i && wr_sel_i == SEL_WIDTH'(i)) begin
        wr_hit[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    minsoc_clock_divider_chan #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (clk_i),
      .rst     (rst_i),
      .wr_en   (wr_hit[g]),
      .wr_data (wr_data_i),
      .sync    (sync_i),
      .div     (div_act[g]),
      .clk_div (clk_o[g]),
      .stb     (stb_o[g]),
      .run     (run_o[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (rd_sel_i == SEL_WIDTH'(i)) begin
          rd_data_o <= div_act[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_minsoc_clock_divider_gen.sv
// Bench for minsoc_clock_divider_gen: behavioural model feeds
// a scoreboard queue checked after every clock edge.
module tb_minsoc_clock_divider_gen;

  logic        clk_i = 1'b0;
  logic        rst_i, wr_en_i, sync_i;
  logic [1:0]  wr_sel_i, rd_sel_i;
  logic [15:0] wr_data_i, rd_data_o;
  logic [3:0]  clk_o, stb_o, run_o;

  logic        wr_en3, sync3;
  logic [1:0]  wr_sel3, rd_sel3;
  logic [15:0] wr_data3, rd_data3;
  logic [2:0]  clk3, stb3, run3;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  minsoc_clock_divider_gen dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en_i),
    .wr_sel_i  (wr_sel_i),
    .wr_data_i (wr_data_i),
    .sync_i    (sync_i),
    .rd_sel_i  (rd_sel_i),
    .rd_data_o (rd_data_o),
    .clk_o     (clk_o),
    .stb_o     (stb_o),
    .run_o     (run_o)
  );

  minsoc_clock_divider_gen #(.CHANNELS(3)) dut3 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en3),
    .wr_sel_i  (wr_sel3),
    .wr_data_i (wr_data3),
    .sync_i    (sync3),
    .rd_sel_i  (rd_sel3),
    .rd_data_o (rd_data3),
    .clk_o     (clk3),
    .stb_o     (stb3),
    .run_o     (run3)
  );

  typedef struct packed {
    logic [3:0]  c, s, r;
    logic [15:0] rd;
    logic [2:0]  c3, s3, r3;
    logic [15:0] rd3;
  } exp_t;

  exp_t q[$];

  // Model: md = active divisor, mp = pending, mpos = cycle in period.
  // Index 4 models every channel of dut3 (never written or synced).
  int md[5], mp[5], mpos[5];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic we,
                     input logic [1:0] sel, input logic [15:0] data,
                     input logic sy, input logic [1:0] rs,
                     input logic we3, input logic [1:0] rs3);
    exp_t e;
    int   wd, np;
    logic hit, c, s;
    rst_i = r; wr_en_i = we; wr_sel_i = sel; wr_data_i = data;
    sync_i = sy; rd_sel_i = rs; wr_en3 = we3; rd_sel3 = rs3;
    e = '0;
    wd = (data == 16'd1) ? 2 : int'(data);
    e.rd  = r ? 16'd0 : 16'(md[rs]);
    e.rd3 = (r || rs3 == 2'd3) ? 16'd0 : 16'(md[4]);
    for (int m = 0; m < 5; m++) begin
      c = 1'b0;
      s = 1'b0;
      hit = (m < 4) && we && (sel == m);
      if (r) begin
        md[m] = 5; mp[m] = 5; mpos[m] = 0;
      end else begin
        np = hit ? wd : mp[m];
        if ((sy && m < 4) || md[m] == 0) begin
          md[m] = mp[m];
          mpos[m] = 0;
        end else begin
          c = 2 * mpos[m] < md[m];
          s = mpos[m] == 0;
          mpos[m]++;
          if (mpos[m] == md[m]) begin
            mpos[m] = 0;
            md[m] = mp[m];
          end
        end
        mp[m] = np;
      end
      if (m < 4) begin
        e.c[m] = c; e.s[m] = s; e.r[m] = md[m] != 0;
      end else begin
        e.c3 = {3{c}}; e.s3 = {3{s}}; e.r3 = {3{md[m] != 0}};
      end
    end
    q.push_back(e);
    @(posedge clk_i);
    #1;
    e = q.pop_front();
    check("clk", clk_o, e.c);
    check("stb", stb_o, e.s);
    check("run", run_o, e.r);
    check("rd", rd_data_o, e.rd);
    check("clk3", clk3, e.c3);
    check("stb3", stb3, e.s3);
    check("run3", run3, e.r3);
    check("rd3", rd_data3, e.rd3);
  endtask

  task automatic idle(input int n, input logic [1:0] rs);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, rs, 0, 0);
  endtask

  initial begin
    sync3 = 1'b0; wr_sel3 = 2'd3; wr_data3 = 16'd9;
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_clk", clk_o, 4'h0);
    check("rst_run", run_o, 4'hF);
    idle(7, 2'd1);
    cyc(0, 1, 2'd1, 16'd4, 0, 2'd1, 0, 0);
    check("ch1_old", rd_data_o, 16'd5);
    idle(12, 2'd1);
    check("ch1_new", rd_data_o, 16'd4);
    cyc(0, 1, 2'd2, 16'd0, 0, 2'd2, 0, 0);
    idle(8, 2'd2);
    check("ch2_stop", run_o[2], 1'b0);
    cyc(0, 1, 2'd2, 16'd3, 0, 2'd2, 0, 0);
    idle(8, 2'd2);
    check("ch2_div3", rd_data_o, 16'd3);
    cyc(0, 1, 2'd3, 16'd1, 0, 2'd3, 0, 0);
    idle(8, 2'd3);
    check("ch3_clamp", rd_data_o, 16'd2);
    cyc(0, 1, 2'd0, 16'd3, 0, 2'd0, 0, 0);
    cyc(0, 1, 2'd1, 16'd5, 0, 2'd0, 0, 0);
    cyc(0, 1, 2'd2, 16'd7, 0, 2'd0, 0, 0);
    cyc(0, 1, 2'd3, 16'd2, 0, 2'd0, 0, 0);
    cyc(0, 0, 2'd0, 16'd0, 1, 2'd0, 0, 0);
    idle(1, 2'd0);
    check("sync_clk", clk_o, 4'hF);
    check("sync_stb", stb_o, 4'hF);
    cyc(0, 1, 2'd0, 16'd9, 0, 2'd0, 0, 0);
    check("ch0_high", clk_o[0], 1'b1);
    cyc(1, 0, 2'd0, 16'd0, 0, 2'd0, 0, 0);
    check("midrst_clk", clk_o, 4'h0);
    idle(12, 2'd0);
    check("ch0_after_rst", rd_data_o, 16'd5);
    cyc(0, 0, 2'd0, 16'd0, 0, 2'd0, 1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 2'd0, 16'd0, 0, 2'd0, 0, 2'(i));
      check("u3_rd", rd_data3, (i == 3) ? 16'd0 : 16'd5);
    end
    idle(6, 2'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
